// File: rtl/enc_cbs_block_fifo.sv
// Block-aware show-ahead FIFO between code-block segmentation and the turbo encoder.
// Buffers {sob, bsize, data} words and counts complete code blocks ready for the encoder.
module enc_cbs_block_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 1024,
    parameter int AW        = 10,
    parameter int SMALL_LEN = 132,
    parameter int LARGE_LEN = 768,
    parameter int AFULL_LVL = 1020
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sob,
    input  logic              wr_bsize,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_sob,
    output logic              rd_bsize,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [AW:0]       level,
    output logic              blk_avail,
    output logic [AW:0]       blk_count,
    output logic              overflow,
    output logic              framing_err
);

    typedef enum logic {IDLE, IN_BLK} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL_LVL);
    localparam logic [AW:0] SMALL_L = (AW+1)'(SMALL_LEN);
    localparam logic [AW:0] LARGE_L = (AW+1)'(LARGE_LEN);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    function automatic logic [AW:0] blk_len(input logic bsize);
        return bsize ? LARGE_L : SMALL_L;
    endfunction

    logic [DATA_W+1:0] mem [DEPTH];
    logic [DATA_W+1:0] head;
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       level_q, blk_q, wcnt_q, wcnt_d, len_q, len_d;
    state_t            state_q, state_d;
    logic              ovf_q, ferr_q;
    logic              rd_acc, wr_room, frame_ok, wr_acc, blk_inc, blk_dec;

    assign head        = mem[rptr_q];
    assign empty       = (level_q == '0);
    assign full        = (level_q == DEPTH_L);
    assign almost_full = (level_q >= AFULL_L);
    assign level       = level_q;
    assign blk_count   = blk_q;
    assign blk_avail   = (blk_q != '0);
    assign overflow    = ovf_q;
    assign framing_err = ferr_q;

    // Head word is forced to zero while empty so stale storage never leaks out
    assign rd_data  = empty ? '0 : head[DATA_W-1:0];
    assign rd_bsize = !empty && head[DATA_W];
    assign rd_sob   = !empty && head[DATA_W+1];

    assign rd_acc   = rd_en && !empty;
    assign wr_room  = !full || rd_acc;
    assign frame_ok = (state_q == IN_BLK) || wr_sob;
    assign wr_acc   = wr_en && wr_room && frame_ok;
    assign blk_dec  = rd_acc && rd_sob && (blk_q != '0);

    // A sob word always (re)starts a block, abandoning any partial one uncounted
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        len_d   = len_q;
        blk_inc = 1'b0;
        if (wr_acc) begin
            if (wr_sob) begin
                len_d  = blk_len(wr_bsize);
                wcnt_d = ONE_L;
                if (len_d == ONE_L) begin
                    blk_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = IN_BLK;
                end
            end else begin
                wcnt_d = wcnt_q + ONE_L;
                if (wcnt_d == len_q) begin
                    blk_inc = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wptr_q] <= {wr_sob, wr_bsize, wr_data};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            blk_q   <= '0;
            wcnt_q  <= '0;
            len_q   <= '0;
            state_q <= IDLE;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
            if (wr_acc) wptr_q <= wptr_q + AW'(1);
            if (rd_acc) rptr_q <= rptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + ONE_L;
                2'b01:   level_q <= level_q - ONE_L;
                default: level_q <= level_q;
            endcase
            case ({blk_inc, blk_dec})
                2'b10:   blk_q <= blk_q + ONE_L;
                2'b01:   blk_q <= blk_q - ONE_L;
                default: blk_q <= blk_q;
            endcase
            if (wr_en && frame_ok && !wr_room) ovf_q <= 1'b1;
            if (wr_en && !frame_ok) ferr_q <= 1'b1;
            if (wr_en && (state_q == IN_BLK) && wr_sob) ferr_q <= 1'b1;
        end
    end

endmodule
